// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: shares one synchronous memory port (1-cycle read
// latency) between the reflet CPU and a single external requester.
// The CPU is frozen via cpu_enable while the external side owns memory,
// and a RESTORE cycle re-presents the CPU address so its read data is
// valid again on the first enabled cycle.
module reflet_mem_arbiter #(
  parameter int wordsize  = 16,
  parameter int cpu_burst = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  input  logic                cpu_req,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_enable,
  input  logic                ext_req,
  input  logic [wordsize-1:0] ext_addr,
  input  logic [wordsize-1:0] ext_data_out,
  input  logic                ext_write_en,
  output logic [wordsize-1:0] ext_data_in,
  output logic                ext_ack,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  input  logic [wordsize-1:0] mem_data_in
);

  // Burst counter holds 0..cpu_burst-1; keep at least one bit for cpu_burst=1.
  localparam int BW = (cpu_burst > 1) ? $clog2(cpu_burst) : 1;
  localparam logic [BW-1:0] BLAST = BW'(cpu_burst - 1);

  localparam logic [1:0] CPU_RUN  = 2'd0;
  localparam logic [1:0] EXT_ADDR = 2'd1;
  localparam logic [1:0] EXT_DATA = 2'd2;
  localparam logic [1:0] RESTORE  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          cpu_active;

  assign cpu_active = run_en && cpu_req;

  // Read data is wired straight through; ownership decides who uses it.
  assign cpu_data_in = mem_data_in;
  assign ext_data_in = mem_data_in;

  // Next-state and burst-count logic.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      CPU_RUN: begin
        if (ext_req && (!cpu_active || bcnt == BLAST)) begin
          state_nxt = EXT_ADDR;
          bcnt_nxt  = '0;
        end else if (ext_req) begin
          bcnt_nxt = bcnt + 1'b1;
        end else begin
          // Count only accumulates while the external side is waiting.
          bcnt_nxt = '0;
        end
      end
      EXT_ADDR: state_nxt = EXT_DATA;
      // Back-to-back external accesses only when the CPU has no use for
      // memory; otherwise hand back through RESTORE.
      EXT_DATA: state_nxt = (ext_req && !cpu_active) ? EXT_ADDR : RESTORE;
      RESTORE:  state_nxt = CPU_RUN;
      default:  state_nxt = RESTORE;
    endcase
  end

  // State register; reset parks in RESTORE so the CPU starts with valid data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESTORE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Memory port steering and handshake outputs, combinational from state.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_data_out = cpu_data_out;
    mem_write_en = 1'b0;
    cpu_enable   = 1'b0;
    ext_ack      = 1'b0;
    if (!reset) begin
      case (state)
        CPU_RUN: begin
          // A frozen CPU must never leak a write strobe into memory.
          mem_write_en = cpu_write_en && run_en;
          cpu_enable   = run_en;
        end
        EXT_ADDR: begin
          mem_addr     = ext_addr;
          mem_data_out = ext_data_out;
          mem_write_en = ext_write_en;
        end
        EXT_DATA: begin
          mem_addr     = ext_addr;
          mem_data_out = ext_data_out;
          ext_ack      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Directed bench for reflet_mem_arbiter: behavioural 1-cycle-latency memory,
// shadow memory for expected read data, scoreboard queue of pending
// external accesses popped on ext_ack.
module tb_reflet_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en, cpu_req, cpu_write_en;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in;
  logic        cpu_enable;
  logic        ext_req, ext_write_en, ext_ack;
  logic [15:0] ext_addr, ext_data_out, ext_data_in;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_write_en;

  reflet_mem_arbiter #(.wordsize(16), .cpu_burst(4)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_write_en(cpu_write_en),
    .cpu_data_in(cpu_data_in), .cpu_enable(cpu_enable),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_data_out(ext_data_out),
    .ext_write_en(ext_write_en), .ext_data_in(ext_data_in), .ext_ack(ext_ack),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_write_en(mem_write_en),
    .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Synchronous memory with registered read data.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[7:0]] <= mem_data_out;
    mem_data_in <= mem[mem_addr[7:0]];
  end

  typedef struct {
    logic        rd;
    logic [15:0] data;
  } sb_t;

  sb_t         sbq[$];
  logic [15:0] shadow [256];
  int          checks = 0;
  int          failures = 0;
  int          acks = 0;
  int          ext_rep = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let outputs settle, retire any ack against the scoreboard, and play the
  // requester: drop ext_req in the ack cycle or chain the next address.
  task automatic look();
    sb_t e;
    #3;
    if (ext_ack) begin
      acks++;
      check("ack_expected", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.rd) check("ext_rdata", 32'(ext_data_in), 32'(e.data));
      end
      if (ext_rep > 0) begin
        ext_rep--;
        ext_addr = ext_addr + 16'd1;
        e.rd = 1'b1;
        e.data = shadow[ext_addr[7:0]];
        sbq.push_back(e);
      end else begin
        ext_req = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin look(); tick(); end
  endtask

  task automatic ext_op(input logic [15:0] a, input logic [15:0] d, input logic we);
    sb_t e;
    ext_addr = a; ext_data_out = d; ext_write_en = we; ext_req = 1'b1;
    if (we) shadow[a[7:0]] = d;
    e.rd = !we;
    e.data = shadow[a[7:0]];
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    int a0, n;
    a0 = acks; n = 0;
    while (acks == a0 && n < 10) begin look(); tick(); n++; end
    check({tag, "_ack"}, 32'(acks - a0), 32'd1);
    if (acks == a0) begin ext_req = 1'b0; sbq.delete(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pre [4];
    logic [7:0]  en8;
    logic [4:0]  en5;
    int          ackc[$];
    int          a0;

    // Reset values
    reset = 1'b1; run_en = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0010;
    cpu_data_out = 16'hABCD; cpu_write_en = 1'b1;
    ext_req = 1'b0; ext_addr = 16'h0; ext_data_out = 16'h0; ext_write_en = 1'b0;
    #2;
    check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
    check("rst_ext_ack", 32'(ext_ack), 32'd0);
    check("rst_mem_we", 32'(mem_write_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h10);
    check("rst_mem_dout", 32'(mem_data_out), 32'hABCD);
    tick(); tick();
    reset = 1'b0; cpu_write_en = 1'b0;

    // 20 cycles of pure CPU running
    look();
    check("post_rst_restore_en", 32'(cpu_enable), 32'd0);
    tick();
    for (int i = 0; i < 19; i++) begin
      cpu_addr = 16'h0040 + 16'(i);
      look();
      check("run_en", 32'(cpu_enable), 32'd1);
      check("run_addr", 32'(mem_addr), 32'(cpu_addr));
      check("run_noack", 32'(ext_ack), 32'd0);
      tick();
    end

    // Preload 0x20..0x23 with the CPU frozen
    pre[0] = 16'hBEEF; pre[1] = 16'hA1A1; pre[2] = 16'hB2B2; pre[3] = 16'hC3C3;
    run_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ext_op(16'h0020 + 16'(i), pre[i], 1'b1);
      wait_ack("preload");
    end

    // Burst-limited ext read of 0x20 while CPU fetches 0x21
    run_en = 1'b1; cpu_addr = 16'h0021;
    idle(3);
    en8 = 8'b1000_1111;
    ext_op(16'h0020, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      look();
      check("burst_en", 32'(cpu_enable), 32'(en8[i]));
      check("burst_addr", 32'(mem_addr), (i == 4 || i == 5) ? 32'h20 : 32'h21);
      check("burst_ack", 32'(ext_ack), 32'(i == 5));
      if (i == 7) check("restore_cpu_data", 32'(cpu_data_in), 32'(shadow[8'h21]));
      tick();
    end

    // Simultaneous CPU write (last burst cycle) and ext write
    cpu_addr = 16'h0007; cpu_data_out = 16'hCAFE;
    idle(2);
    shadow[8'h07] = 16'hCAFE;
    ext_op(16'h0005, 16'h1234, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) cpu_write_en = 1'b1;
      if (i == 7) cpu_write_en = 1'b0;
      look();
      check("wr_we", 32'(mem_write_en), 32'(i == 3 || i == 4));
      if (i == 3) begin
        check("wr_cpu_addr", 32'(mem_addr), 32'h07);
        check("wr_cpu_data", 32'(mem_data_out), 32'hCAFE);
      end
      if (i == 4) begin
        check("wr_ext_addr", 32'(mem_addr), 32'h05);
        check("wr_ext_data", 32'(mem_data_out), 32'h1234);
      end
      tick();
    end
    ext_op(16'h0005, 16'h0, 1'b0);
    wait_ack("rb05");
    ext_op(16'h0007, 16'h0, 1'b0);
    wait_ack("rb07");

    // run_en low: four back-to-back reads, one every 2 cycles, no RESTORE
    run_en = 1'b0; cpu_addr = 16'h0099;
    idle(2);
    ext_rep = 3;
    ext_op(16'h0020, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a0 = acks;
      look();
      if (acks != a0) ackc.push_back(i);
      check("b2b_en", 32'(cpu_enable), 32'd0);
      if (i >= 1 && i <= 8) check("b2b_no_restore", 32'(mem_addr), 32'(ext_addr));
      tick();
    end
    check("b2b_count", 32'(ackc.size()), 32'd4);
    foreach (ackc[k]) check("b2b_spacing", 32'(ackc[k]), 32'(2 + 2 * k));

    // Reset in EXT_DATA of a write
    idle(2);
    ext_op(16'h0030, 16'h5555, 1'b1);
    look(); tick();
    look();
    check("rst_ea_we", 32'(mem_write_en), 32'd1);
    check("rst_ea_addr", 32'(mem_addr), 32'h30);
    tick();
    #1;
    check("rst_ed_ack_before", 32'(ext_ack), 32'd1);
    reset = 1'b1; ext_req = 1'b0;
    #1;
    check("rst_ed_ack", 32'(ext_ack), 32'd0);
    check("rst_ed_we", 32'(mem_write_en), 32'd0);
    sbq.delete();
    look(); tick();
    reset = 1'b0; run_en = 1'b1;
    look();
    check("rst_rel_restore", 32'(cpu_enable), 32'd0);
    tick();
    look();
    check("rst_rel_run", 32'(cpu_enable), 32'd1);
    tick();
    ext_op(16'h0030, 16'h0, 1'b0);
    wait_ack("rb30");

    // cpu_req low: no burst wait
    cpu_req = 1'b0; cpu_addr = 16'h0044;
    idle(2);
    en5 = 5'b10001;
    ext_op(16'h0022, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      look();
      check("idle_en", 32'(cpu_enable), 32'(en5[i]));
      check("idle_ack", 32'(ext_ack), 32'(i == 2));
      check("idle_addr", 32'(mem_addr), (i == 1 || i == 2) ? 32'h22 : 32'h44);
      tick();
    end
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
